// File: rtl/ramb16_rd_pkg.sv
// Shared types and geometry for the block-RAM stream reader.
package ramb16_rd_pkg;

  localparam int unsigned RAM_ADDR_W = 13;
  localparam int unsigned RAM_DATA_W = 2;
  localparam int unsigned RAM_WORDS  = 8192;
  localparam int unsigned RAM_LEN_W  = RAM_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/ramb16_rd_fifo.sv
// Small synchronous FIFO with the head word always visible on pop_data.
module ramb16_rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  // Storage is reset so the head word reads as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/ramb16_stream_reader.sv
// Walks an address range on one RAMB16 read port and streams the words out
// with valid/ready backpressure and a LAST marker.
module ramb16_stream_reader
  import ramb16_rd_pkg::*;
#(
  parameter int unsigned ADDR_W     = RAM_ADDR_W,
  parameter int unsigned DATA_W     = RAM_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_SSR,
  output logic [ADDR_W-1:0] RAM_ADDR,
  input  logic [DATA_W-1:0] RAM_DO,
  output logic [DATA_W-1:0] M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_LAST
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRD_W = CNT_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  rd_cnt;
  logic              cap;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   head;
  logic              push_last;
  logic              pop;
  logic              credit;

  assign RAM_WE  = 1'b0;
  assign RAM_SSR = 1'b0;

  assign M_VALID = ~fifo_empty;
  assign M_DATA  = head[DATA_W-1:0];
  assign M_LAST  = head[DATA_W] & ~fifo_empty;
  assign pop     = M_VALID & M_READY;

  // Reserve a slot for every read still in the two-stage RAM pipe.
  assign credit = ~(fifo_full & ~pop) &
                  ((CRD_W'(fifo_count) + CRD_W'(cap) + CRD_W'(RAM_EN)) <
                   (CRD_W'(FIFO_DEPTH) + CRD_W'(pop)));

  assign push_last = (rd_cnt == (len - 1'b1));

  ramb16_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (cap),
    .push_data ({push_last, RAM_DO}),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // cap marks the cycle in which RAM_DO carries the word issued one cycle earlier.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      base      <= '0;
      len       <= '0;
      issue_cnt <= '0;
      rd_cnt    <= '0;
      cap       <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RAM_EN    <= 1'b0;
      RAM_ADDR  <= '0;
    end else begin
      cap    <= RAM_EN;
      DONE   <= 1'b0;
      RAM_EN <= 1'b0;
      if (cap) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (START) begin
            base   <= BASE_ADDR;
            len    <= LEN;
            rd_cnt <= '0;
            if (LEN == '0) begin
              state     <= FINISH;
              DONE      <= 1'b1;
              issue_cnt <= '0;
            end else begin
              state     <= ISSUE;
              BUSY      <= 1'b1;
              RAM_EN    <= 1'b1;
              RAM_ADDR  <= BASE_ADDR;
              issue_cnt <= LEN_W'(1);
            end
          end
        end
        ISSUE: begin
          if (issue_cnt == len) begin
            state <= DRAIN;
          end else if (credit) begin
            RAM_EN    <= 1'b1;
            RAM_ADDR  <= base + issue_cnt[ADDR_W-1:0];
            issue_cnt <= issue_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (pop && M_LAST) begin
            state <= FINISH;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ramb16_stream_reader.sv
// Directed bench for ramb16_stream_reader against a registered-read RAM model.
module tb_ramb16_stream_reader;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 2;
  localparam int unsigned DEPTH  = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              START;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [ADDR_W:0]   LEN;
  logic              BUSY;
  logic              DONE;
  logic              RAM_EN;
  logic              RAM_WE;
  logic              RAM_SSR;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] ram_do = '0;
  logic [DATA_W-1:0] M_DATA;
  logic              M_VALID;
  logic              M_READY;
  logic              M_LAST;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) edges <= edges + 1;

  // RAM content: word i holds i mod 4; output holds while disabled.
  always @(posedge CLK) if (RAM_EN) ram_do <= RAM_ADDR[1:0];

  ramb16_stream_reader u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .BASE_ADDR (BASE_ADDR),
    .LEN       (LEN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RAM_EN    (RAM_EN),
    .RAM_WE    (RAM_WE),
    .RAM_SSR   (RAM_SSR),
    .RAM_ADDR  (RAM_ADDR),
    .RAM_DO    (ram_do),
    .M_DATA    (M_DATA),
    .M_VALID   (M_VALID),
    .M_READY   (M_READY),
    .M_LAST    (M_LAST)
  );

  logic [ADDR_W-1:0] en_addr [$];
  int                en_edge [$];
  logic [DATA_W-1:0] wd_data [$];
  logic              wd_last [$];
  int                wd_edge [$];
  int                done_edge [$];
  int                busy_cyc = 0;
  int                busy_at_done = 0;
  int                stab_err = 0;
  int                max_cnt = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;

  // Mid-cycle observer: logs RAM issues, handshakes, DONE pulses and stall stability.
  always @(negedge CLK) begin
    if (!RST) begin
      if (RAM_EN) begin
        en_addr.push_back(RAM_ADDR);
        en_edge.push_back(edges);
      end
      if (M_VALID && M_READY) begin
        wd_data.push_back(M_DATA);
        wd_last.push_back(M_LAST);
        wd_edge.push_back(edges);
      end
      if (DONE) begin
        done_edge.push_back(edges);
        if (BUSY) busy_at_done++;
      end
      if (BUSY) busy_cyc++;
      if (prev_stall && (!M_VALID || M_DATA !== prev_data || M_LAST !== prev_last)) stab_err++;
      if (int'(u_dut.fifo_count) > max_cnt) max_cnt = int'(u_dut.fifo_count);
    end
    prev_stall = M_VALID && !M_READY;
    prev_data  = M_DATA;
    prev_last  = M_LAST;
  end

  task automatic start_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l, output int s);
    BASE_ADDR = b;
    LEN       = l;
    START     = 1'b1;
    @(posedge CLK); #1;
    s     = edges;
    START = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(posedge CLK); #1;
      if (done_edge.size() > d0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, RAM_EN, M_VALID, M_LAST} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000", {BUSY, DONE, RAM_EN, M_VALID, M_LAST});
    end
    checks++;
    if (RAM_ADDR !== '0) begin
      errors++;
      $display("FAIL reset_addr got %h exp 0000", RAM_ADDR);
    end
    checks++;
    if ({RAM_WE, RAM_SSR} !== 2'b00) begin
      errors++;
      $display("FAIL reset_we_ssr got %b exp 00", {RAM_WE, RAM_SSR});
    end
    #2 RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic;
    int e0, w0, d0, b0, s;
    bit ok;
    e0 = en_addr.size(); w0 = wd_data.size(); d0 = done_edge.size(); b0 = busy_at_done;
    M_READY = 1'b1;
    start_cmd(13'h0010, 14'd5, s);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b exp 1", BUSY);
    end
    wait_done(d0, 40, ok);
    repeat (3) @(posedge CLK); #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout got no DONE exp DONE");
    end
    checks++;
    if (en_addr.size() - e0 !== 5) begin
      errors++;
      $display("FAIL basic_issues got %0d exp 5", en_addr.size() - e0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (en_addr[e0+i] !== ADDR_W'(16 + i) || en_edge[e0+i] !== s + i) begin
          errors++;
          $display("FAIL basic_issue%0d got %h@%0d exp %h@%0d", i, en_addr[e0+i], en_edge[e0+i], 16 + i, s + i);
        end
      end
    end
    checks++;
    if (wd_data.size() - w0 !== 5) begin
      errors++;
      $display("FAIL basic_words got %0d exp 5", wd_data.size() - w0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wd_data[w0+i] !== DATA_W'(i % 4) || wd_last[w0+i] !== (i == 4) || wd_edge[w0+i] !== s + 2 + i) begin
          errors++;
          $display("FAIL basic_word%0d got %0d/%b@%0d exp %0d/%b@%0d", i, wd_data[w0+i], wd_last[w0+i],
                   wd_edge[w0+i], i % 4, i == 4, s + 2 + i);
        end
      end
    end
    checks++;
    if (done_edge.size() - d0 !== 1 || done_edge[d0] !== s + 7) begin
      errors++;
      $display("FAIL basic_done got %0d pulses first@%0d exp 1@%0d", done_edge.size() - d0, done_edge[d0], s + 7);
    end
    checks++;
    if (busy_at_done !== b0) begin
      errors++;
      $display("FAIL basic_busy_at_done got %0d exp %0d", busy_at_done, b0);
    end
  endtask

  task automatic test_len0;
    int e0, w0, d0, bc0, s;
    bit ok;
    e0 = en_addr.size(); w0 = wd_data.size(); d0 = done_edge.size(); bc0 = busy_cyc;
    start_cmd(13'h0055, 14'd0, s);
    checks++;
    if ({DONE, BUSY} !== 2'b10) begin
      errors++;
      $display("FAIL len0_first_cycle got done/busy %b exp 10", {DONE, BUSY});
    end
    wait_done(d0, 10, ok);
    repeat (3) @(posedge CLK); #1;
    checks++;
    if (!ok || done_edge.size() - d0 !== 1 || done_edge[d0] !== s) begin
      errors++;
      $display("FAIL len0_done got %0d pulses first@%0d exp 1@%0d", done_edge.size() - d0, done_edge[d0], s);
    end
    checks++;
    if (en_addr.size() - e0 !== 0 || wd_data.size() - w0 !== 0) begin
      errors++;
      $display("FAIL len0_activity got en %0d words %0d exp 0 0", en_addr.size() - e0, wd_data.size() - w0);
    end
    checks++;
    if (busy_cyc - bc0 > 1) begin
      errors++;
      $display("FAIL len0_busy got %0d cycles exp <=1", busy_cyc - bc0);
    end
  endtask

  task automatic test_wrap;
    logic [ADDR_W-1:0] ea [4];
    logic [DATA_W-1:0] ed [4];
    int e0, w0, d0, s;
    bit ok;
    ea = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    ed = '{2'd2, 2'd3, 2'd0, 2'd1};
    e0 = en_addr.size(); w0 = wd_data.size(); d0 = done_edge.size();
    M_READY = 1'b1;
    start_cmd(13'h1FFE, 14'd4, s);
    wait_done(d0, 40, ok);
    repeat (3) @(posedge CLK); #1;
    checks++;
    if (!ok || en_addr.size() - e0 !== 4 || wd_data.size() - w0 !== 4) begin
      errors++;
      $display("FAIL wrap_counts got en %0d words %0d done %b exp 4 4 1", en_addr.size() - e0, wd_data.size() - w0, ok);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (en_addr[e0+i] !== ea[i] || wd_data[w0+i] !== ed[i] || wd_last[w0+i] !== (i == 3)) begin
          errors++;
          $display("FAIL wrap_item%0d got %h/%0d/%b exp %h/%0d/%b", i, en_addr[e0+i], wd_data[w0+i],
                   wd_last[w0+i], ea[i], ed[i], i == 3);
        end
      end
      checks++;
      if (done_edge[d0] !== s + 6) begin
        errors++;
        $display("FAIL wrap_done_time got %0d exp %0d", done_edge[d0], s + 6);
      end
    end
  endtask

  task automatic test_backpressure;
    int e0, w0, d0, st0, s, nlast;
    bit ok;
    e0 = en_addr.size(); w0 = wd_data.size(); d0 = done_edge.size(); st0 = stab_err;
    M_READY = 1'b1;
    start_cmd(13'h0005, 14'd16, s);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      M_READY = (k % 3 == 0);
      @(posedge CLK); #1;
      if (done_edge.size() > d0) ok = 1'b1;
    end
    M_READY = 1'b1;
    repeat (3) @(posedge CLK); #1;
    checks++;
    if (!ok || wd_data.size() - w0 !== 16 || en_addr.size() - e0 !== 16) begin
      errors++;
      $display("FAIL bp_counts got words %0d en %0d done %b exp 16 16 1", wd_data.size() - w0, en_addr.size() - e0, ok);
    end else begin
      nlast = 0;
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (wd_data[w0+i] !== DATA_W'((5 + i) % 4) || en_addr[e0+i] !== ADDR_W'(5 + i)) begin
          errors++;
          $display("FAIL bp_item%0d got %0d@%h exp %0d@%h", i, wd_data[w0+i], en_addr[e0+i], (5 + i) % 4, 5 + i);
        end
        if (wd_last[w0+i]) nlast++;
      end
      checks++;
      if (nlast !== 1 || wd_last[w0+15] !== 1'b1) begin
        errors++;
        $display("FAIL bp_last got %0d marks final=%b exp 1 final=1", nlast, wd_last[w0+15]);
      end
      checks++;
      if (en_edge[e0+15] - en_edge[e0] <= 15) begin
        errors++;
        $display("FAIL bp_issue_pause got span %0d exp >15", en_edge[e0+15] - en_edge[e0]);
      end
    end
    checks++;
    if (stab_err !== st0) begin
      errors++;
      $display("FAIL bp_stall_stable got %0d violations exp 0", stab_err - st0);
    end
    checks++;
    if (max_cnt > DEPTH) begin
      errors++;
      $display("FAIL bp_fifo_bound got %0d exp <=%0d", max_cnt, DEPTH);
    end
  endtask

  task automatic test_start_while_busy;
    int e0, w0, d0, s, s2;
    bit ok;
    e0 = en_addr.size(); w0 = wd_data.size(); d0 = done_edge.size();
    M_READY = 1'b1;
    start_cmd(13'h0020, 14'd6, s);
    @(posedge CLK); #1;
    start_cmd(13'h0100, 14'd2, s2);
    wait_done(d0, 40, ok);
    repeat (8) @(posedge CLK); #1;
    checks++;
    if (!ok || done_edge.size() - d0 !== 1) begin
      errors++;
      $display("FAIL busy_start_done got %0d pulses exp 1", done_edge.size() - d0);
    end
    checks++;
    if (en_addr.size() - e0 !== 6 || wd_data.size() - w0 !== 6) begin
      errors++;
      $display("FAIL busy_start_counts got en %0d words %0d exp 6 6", en_addr.size() - e0, wd_data.size() - w0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (en_addr[e0+i] !== ADDR_W'(32 + i) || wd_data[w0+i] !== DATA_W'(i % 4) || wd_last[w0+i] !== (i == 5)) begin
          errors++;
          $display("FAIL busy_start_item%0d got %h/%0d/%b exp %h/%0d/%b", i, en_addr[e0+i], wd_data[w0+i],
                   wd_last[w0+i], 32 + i, i % 4, i == 5);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int w0, d0, s;
    bit ok;
    w0 = wd_data.size(); d0 = done_edge.size();
    M_READY = 1'b1;
    start_cmd(13'h0000, 14'd8, s);
    ok = 1'b0;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(posedge CLK); #1;
      if (wd_data.size() - w0 >= 3) ok = 1'b1;
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (!ok || {BUSY, DONE, RAM_EN, M_VALID, M_LAST} !== 5'b0 || RAM_ADDR !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %b addr %h reached3=%b exp 00000 addr 0000", {BUSY, DONE, RAM_EN, M_VALID, M_LAST},
               RAM_ADDR, ok);
    end
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (done_edge.size() - d0 !== 0) begin
      errors++;
      $display("FAIL midreset_no_done got %0d pulses exp 0", done_edge.size() - d0);
    end
    w0 = wd_data.size(); d0 = done_edge.size();
    start_cmd(13'h0040, 14'd2, s);
    wait_done(d0, 30, ok);
    repeat (4) @(posedge CLK); #1;
    checks++;
    if (!ok || done_edge.size() - d0 !== 1 || done_edge[d0] !== s + 4) begin
      errors++;
      $display("FAIL midreset_done got %0d pulses first@%0d exp 1@%0d", done_edge.size() - d0, done_edge[d0], s + 4);
    end
    checks++;
    if (wd_data.size() - w0 !== 2) begin
      errors++;
      $display("FAIL midreset_words got %0d exp 2", wd_data.size() - w0);
    end else begin
      checks++;
      if (wd_data[w0] !== 2'd0 || wd_data[w0+1] !== 2'd1 || wd_last[w0] !== 1'b0 || wd_last[w0+1] !== 1'b1) begin
        errors++;
        $display("FAIL midreset_data got %0d/%b %0d/%b exp 0/0 1/1", wd_data[w0], wd_last[w0], wd_data[w0+1], wd_last[w0+1]);
      end
    end
  endtask

  initial begin
    RST       = 1'b1;
    START     = 1'b0;
    BASE_ADDR = '0;
    LEN       = '0;
    M_READY   = 1'b0;
    test_reset;
    test_basic;
    test_len0;
    test_wrap;
    test_backpressure;
    test_start_while_busy;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
